// File: rtl/data_bus_responder.sv
// ============================================================================
// data_bus_responder : CPU data-bus responder (word RAM, timer, LED, switches,
//                      7-seg, systick) with one-cycle load latency
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_bus_responder #(
   parameter int          RAM_WORDS   = 512,
   parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] clk_count,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [7:0]  switches,
   output logic [31:0] read_data,
   output logic        clk_ecp,
   output logic [7:0]  leds,
   output logic [11:0] digits
);

   localparam int         AW       = $clog2(RAM_WORDS);
   localparam logic [2:0] REG_TH   = 3'd0;
   localparam logic [2:0] REG_TL   = 3'd1;
   localparam logic [2:0] REG_TCON = 3'd2;
   localparam logic [2:0] REG_LEDS = 3'd3;
   localparam logic [2:0] REG_SW   = 3'd4;
   localparam logic [2:0] REG_DIG  = 3'd5;
   localparam logic [2:0] REG_TICK = 3'd6;

   logic [31:0]   ram_q [RAM_WORDS];
   logic [31:0]   th_q, th_d;
   logic [31:0]   tl_q, tl_d;
   logic [2:0]    tcon_q, tcon_d;
   logic [7:0]    leds_q, leds_d;
   logic [11:0]   digits_q, digits_d;
   logic [31:0]   read_data_q, read_data_d;

   logic [31:0]   periph_off;
   logic [2:0]    reg_idx;
   logic [AW-1:0] ram_idx;
   logic          ram_hit;
   logic          periph_hit;
   logic          ram_we;
   logic          timer_wr;
   logic [31:0]   rd_sel;
   logic          unused_addr_bits;

   assign periph_off       = address - PERIPH_BASE;
   assign unused_addr_bits = ^periph_off[1:0];
   assign reg_idx          = periph_off[4:2];
   assign ram_idx          = address[AW+1:2];
   assign ram_hit          = (address[31:AW+2] == '0);
   assign periph_hit       = (periph_off[31:5] == '0) && (reg_idx != 3'd7);
   assign ram_we           = mem_write && ram_hit;
   // Any CPU store to TH/TL/TCON pre-empts that edge's timer update entirely.
   assign timer_wr         = mem_write && periph_hit && (reg_idx <= REG_TCON);

   always_comb begin
      rd_sel      = '0;
      th_d        = th_q;
      tl_d        = tl_q;
      tcon_d      = tcon_q;
      leds_d      = leds_q;
      digits_d    = digits_q;

      if (ram_hit) begin
         rd_sel = ram_q[ram_idx];
      end else if (periph_hit) begin
         case (reg_idx)
            REG_TH:   rd_sel = th_q;
            REG_TL:   rd_sel = tl_q;
            REG_TCON: rd_sel = {29'b0, tcon_q};
            REG_LEDS: rd_sel = {24'b0, leds_q};
            REG_SW:   rd_sel = {24'b0, switches};
            REG_DIG:  rd_sel = {20'b0, digits_q};
            REG_TICK: rd_sel = clk_count;
            default:  rd_sel = '0;
         endcase
      end
      read_data_d = mem_read ? rd_sel : '0;

      if (!timer_wr && tcon_q[0]) begin
         if (tl_q == 32'hFFFF_FFFF) begin
            tl_d = th_q;
            if (tcon_q[1]) tcon_d[2] = 1'b1;
         end else begin
            tl_d = tl_q + 32'd1;
         end
      end

      if (mem_write && periph_hit) begin
         case (reg_idx)
            REG_TH:   th_d     = write_data;
            REG_TL:   tl_d     = write_data;
            REG_TCON: tcon_d   = write_data[2:0];
            REG_LEDS: leds_d   = write_data[7:0];
            REG_DIG:  digits_d = write_data[11:0];
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th_q        <= '0;
         tl_q        <= '0;
         tcon_q      <= '0;
         leds_q      <= '0;
         digits_q    <= '0;
         read_data_q <= '0;
      end else begin
         th_q        <= th_d;
         tl_q        <= tl_d;
         tcon_q      <= tcon_d;
         leds_q      <= leds_d;
         digits_q    <= digits_d;
         read_data_q <= read_data_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RAM_WORDS; i++) ram_q[i] <= '0;
      end else if (ram_we) begin
         ram_q[ram_idx] <= write_data;
      end
   end

   assign read_data = read_data_q;
   assign clk_ecp   = tcon_q[1] & tcon_q[2];
   assign leds      = leds_q;
   assign digits    = digits_q;

endmodule

`default_nettype wire

// File: tb/tb_data_bus_responder.sv
// ============================================================================
// tb_data_bus_responder : directed self-checking bench for data_bus_responder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_bus_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] clk_count;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        mem_read;
   logic        mem_write;
   logic [7:0]  switches;
   logic [31:0] read_data;
   logic        clk_ecp;
   logic [7:0]  leds;
   logic [11:0] digits;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] A_TH   = 32'h4000_0000;
   localparam logic [31:0] A_TL   = 32'h4000_0004;
   localparam logic [31:0] A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_LEDS = 32'h4000_000C;
   localparam logic [31:0] A_SW   = 32'h4000_0010;
   localparam logic [31:0] A_DIG  = 32'h4000_0014;
   localparam logic [31:0] A_TICK = 32'h4000_0018;

   data_bus_responder #(.RAM_WORDS(512), .PERIPH_BASE(32'h4000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_count  (clk_count),
      .address    (address),
      .write_data (write_data),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .switches   (switches),
      .read_data  (read_data),
      .clk_ecp    (clk_ecp),
      .leds       (leds),
      .digits     (digits)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      address    = a;
      write_data = d;
      mem_write  = 1'b1;
      tick();
      mem_write  = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      address  = a;
      mem_read = 1'b1;
      tick();
      d        = read_data;
      mem_read = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({read_data, leds, digits, clk_ecp} !== 53'd0) begin
         errors++;
         $display("FAIL reset_outputs: got rd=%h leds=%h dig=%h ecp=%b, want all 0",
                  read_data, leds, digits, clk_ecp);
      end
      reset = 1'b0;
      tick();
      bus_read(A_TL, d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_tl: got %h want 0", d); end
   endtask

   task automatic test_ram();
      logic [31:0] d;
      bus_write(32'h0000_0010, 32'hDEAD_BEEF);
      bus_read(32'h0000_0010, d);
      checks++;
      if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_load: got %h want deadbeef", d); end
      tick();
      checks++;
      if (read_data !== 32'd0) begin errors++; $display("FAIL idle_read: got %h want 0", read_data); end
      // Simultaneous read and write: old contents returned, then new contents.
      address = 32'h0000_0010; write_data = 32'h1234_5678;
      mem_read = 1'b1; mem_write = 1'b1;
      tick();
      mem_read = 1'b0; mem_write = 1'b0;
      checks++;
      if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rbw_old: got %h want deadbeef", read_data); end
      bus_read(32'h0000_0010, d);
      checks++;
      if (d !== 32'h1234_5678) begin errors++; $display("FAIL rbw_new: got %h want 12345678", d); end
      bus_write(32'h0000_07FC, 32'hCAFE_F00D);
      bus_read(32'h0000_07FC, d);
      checks++;
      if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_top: got %h want cafef00d", d); end
      bus_write(32'h0000_0800, 32'hBAD0_BAD0);
      bus_read(32'h0000_0800, d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL ram_oob_read: got %h want 0", d); end
      bus_read(32'h0000_0000, d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL ram_no_alias: got %h want 0", d); end
   endtask

   task automatic test_timer();
      logic [31:0] d;
      bus_write(A_TH, 32'hFFFF_FFFD);
      bus_write(A_TL, 32'hFFFF_FFFE);
      bus_write(A_TCON, 32'd3);
      bus_read(A_TL, d);
      checks++;
      if (d !== 32'hFFFF_FFFE || clk_ecp !== 1'b0) begin
         errors++; $display("FAIL timer_count1: got tl=%h ecp=%b want fffffffe 0", d, clk_ecp);
      end
      bus_read(A_TL, d);
      checks++;
      if (d !== 32'hFFFF_FFFF || clk_ecp !== 1'b1) begin
         errors++; $display("FAIL timer_overflow: got tl=%h ecp=%b want ffffffff 1", d, clk_ecp);
      end
      bus_read(A_TL, d);
      checks++;
      if (d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL timer_reload: got %h want fffffffd", d); end
      bus_read(A_TCON, d);
      checks++;
      if (d !== 32'd7) begin errors++; $display("FAIL tcon_status: got %h want 7", d); end
      // TL now FFFF_FFFF; the clearing write suppresses this edge's overflow.
      bus_write(A_TCON, 32'd3);
      checks++;
      if (clk_ecp !== 1'b0) begin errors++; $display("FAIL irq_clear: got ecp=%b want 0", clk_ecp); end
      bus_read(A_TL, d);
      checks++;
      if (d !== 32'hFFFF_FFFF || clk_ecp !== 1'b1) begin
         errors++; $display("FAIL timer_resume: got tl=%h ecp=%b want ffffffff 1", d, clk_ecp);
      end
   endtask

   task automatic test_overflow_write();
      logic [31:0] d;
      bus_write(A_TCON, 32'd3);
      tick();
      tick();
      bus_write(A_TL, 32'd5);
      checks++;
      if (clk_ecp !== 1'b0) begin errors++; $display("FAIL ovf_write_ecp: got %b want 0", clk_ecp); end
      bus_read(A_TL, d);
      checks++;
      if (d !== 32'd5) begin errors++; $display("FAIL ovf_write_tl: got %h want 5", d); end
      bus_read(A_TCON, d);
      checks++;
      if (d !== 32'd3) begin errors++; $display("FAIL ovf_write_tcon: got %h want 3", d); end
      bus_write(A_TCON, 32'd0);
   endtask

   task automatic test_periph();
      logic [31:0] d;
      switches = 8'hA5;
      bus_read(A_SW, d);
      checks++;
      if (d !== 32'h0000_00A5) begin errors++; $display("FAIL switches: got %h want 000000a5", d); end
      bus_write(A_LEDS, 32'h0000_01FE);
      checks++;
      if (leds !== 8'hFE) begin errors++; $display("FAIL leds: got %h want fe", leds); end
      bus_write(A_DIG, 32'hFFFF_F123);
      checks++;
      if (digits !== 12'h123) begin errors++; $display("FAIL digits: got %h want 123", digits); end
      bus_read(A_DIG, d);
      checks++;
      if (d !== 32'h0000_0123) begin errors++; $display("FAIL digits_read: got %h want 00000123", d); end
      clk_count = 32'h1111_2222;
      bus_write(A_TICK, 32'h9999_9999);
      bus_read(A_TICK, d);
      checks++;
      if (d !== 32'h1111_2222) begin errors++; $display("FAIL systick: got %h want 11112222", d); end
      bus_read(32'h5000_0000, d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL unmapped: got %h want 0", d); end
      bus_read(32'h4000_001C, d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL periph_hole: got %h want 0", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      bus_write(A_TCON, 32'd3);
      bus_read(A_LEDS, d);
      checks++;
      if (d !== 32'h0000_00FE) begin errors++; $display("FAIL leds_read: got %h want 000000fe", d); end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({read_data, leds, digits, clk_ecp} !== 53'd0) begin
         errors++;
         $display("FAIL async_reset: got rd=%h leds=%h dig=%h ecp=%b, want all 0",
                  read_data, leds, digits, clk_ecp);
      end
      tick();
      reset = 1'b0;
      bus_read(A_TL, d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_mid_tl: got %h want 0", d); end
      bus_read(A_TCON, d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_mid_tcon: got %h want 0", d); end
      bus_read(32'h0000_0010, d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_mid_ram: got %h want 0", d); end
   endtask

   initial begin
      reset      = 1'b1;
      clk_count  = 32'd0;
      address    = 32'd0;
      write_data = 32'd0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      switches   = 8'd0;
      test_reset();
      test_ram();
      test_timer();
      test_overflow_write();
      test_periph();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
